// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Request/result bundle for serial_subtractor (ovf present only when
//            SERIAL_SUB_OVF_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial a - b, LSB first, registered borrow, done strobe.
//            Optional macro SERIAL_SUB_OVF_EN adds signed overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam int              c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [c_cw-1:0]  r_count;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_d;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs
    assign w_d           = r_sa[0] ^ r_sb[0] ^ r_borrow;
    assign w_borrow_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
    assign w_res_next    = {w_d, r_res[WIDTH-1:1]};
    assign w_last        = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start seen in DONE chains straight into the next operation
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa         <= '0;
            r_sb         <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sa     <= bus.a;
                r_sb     <= bus.b;
                r_res    <= '0;
                r_borrow <= 1'b0;
                r_count  <= '0;
                r_busy   <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
                r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
                r_res    <= w_res_next;
                r_borrow <= w_borrow_next;
                r_count  <= r_count + c_one;
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_diff       <= w_res_next;
                    r_borrow_out <= w_borrow_next;
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_sign;
    logic r_b_sign;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sign <= bus.a[WIDTH-1];
                r_b_sign <= bus.b[WIDTH-1];
            end else if ((r_state == S_RUN) && w_last) begin
                r_ovf <= (r_a_sign != r_b_sign) && (w_res_next[WIDTH-1] != r_a_sign);
            end
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed and random bench for serial_subtractor with an
//            operation-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x - y;
        return (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    endfunction

    // Operation-level model: an accepted start finishes W edges later
    int           cyc = 0;
    logic         m_pend;
    int           m_end;
    logic [W-1:0] m_a, m_b;
    logic         m_done;
    logic [W-1:0] m_diff;
    logic         m_bo;
    logic         m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bo   <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_pend && cyc == m_end) begin
                m_done <= 1'b1;
                m_diff <= m_a - m_b;
                m_bo   <= (m_a < m_b);
                m_ovf  <= ovf_of(m_a, m_b);
                m_pend <= 1'b0;
            end
            if (bus.start && !m_pend) begin
                m_pend <= 1'b1;
                m_end  <= cyc + W;
                m_a    <= bus.a;
                m_b    <= bus.b;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(bus.busy), 64'(m_pend));
            check("done", 64'(bus.done), 64'(m_done));
            check("diff", 64'(bus.diff), 64'(m_diff));
            check("borrow_out", 64'(bus.borrow_out), 64'(m_bo));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", 64'(bus.ovf), 64'(m_ovf));
`endif
        end
    end

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int inj, output int lat);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        lat       = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (inj != 0 && lat == inj) begin
                bus.start = 1'b1;
                bus.a     = 8'd1;
                bus.b     = 8'd2;
            end
            if (inj != 0 && lat == inj + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) break;
        end
        if (bus.done !== 1'b1) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic op_lit(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb);
        int lat;
        run_op(ta, tb_v, 0, lat);
        check({nm, "_latency"}, 64'(lat), 64'd9);
        check({nm, "_diff"}, 64'(bus.diff), 64'(ed));
        check({nm, "_borrow"}, 64'(bus.borrow_out), 64'(eb));
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_diff", 64'(bus.diff), 64'd0);
        check("rst_borrow", 64'(bus.borrow_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op_lit("t1", 8'd10, 8'd3, 8'h07, 1'b0);
        op_lit("t2a", 8'd3, 8'd10, 8'hF9, 1'b1);
        op_lit("t2b", 8'hFF, 8'hFF, 8'h00, 1'b0);
        op_lit("t2c", 8'h00, 8'h01, 8'hFF, 1'b1);

        run_op(8'd20, 8'd5, 3, lat);
        check("t3_latency", 64'(lat), 64'd9);
        check("t3_diff", 64'(bus.diff), 64'h0F);
        check("t3_borrow", 64'(bus.borrow_out), 64'd0);
        repeat (12) @(negedge clk);

        op_lit("t4_first", 8'd9, 8'd4, 8'h05, 1'b0);
        op_lit("t4_chain", 8'd100, 8'd50, 8'h32, 1'b0);
        repeat (3) @(negedge clk);

        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_done", 64'(bus.done), 64'd0);
        check("t5_diff", 64'(bus.diff), 64'd0);
        check("t5_borrow", 64'(bus.borrow_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op_lit("t5_eq", 8'd7, 8'd7, 8'h00, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        op_lit("t6a", 8'h80, 8'h01, 8'h7F, 1'b0);
        check("t6a_ovf", 64'(bus.ovf), 64'd1);
        op_lit("t6b", 8'h7F, 8'hFF, 8'h80, 1'b1);
        check("t6b_ovf", 64'(bus.ovf), 64'd1);
        op_lit("t6c", 8'h05, 8'h03, 8'h02, 1'b0);
        check("t6c_ovf", 64'(bus.ovf), 64'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 299) != 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            if ($urandom_range(0, 7) == 0) bus.b = bus.a;
        end
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor computing diff = a - b one bit per clock, LSB first. It uses the full-subtractor recurrence, the inverse of the full-adder cell, with a registered borrow. It is the area-optimised counterpart to the combinational adder cells in the arithmetic library. Operands are loaded on a start pulse, and completion is signalled with a one-cycle done strobe.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; operands sampled when start=1 and block not busy
a  input  WIDTH  minuend, sampled on accepted start only
b  input  WIDTH  subtrahend, sampled on accepted start only
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle strobe; diff/borrow_out valid from this cycle
diff  output  WIDTH  result a - b modulo 2^WIDTH
borrow_out  output  1  final borrow; 1 when a < b (unsigned)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift registers, bit counter and borrow cleared. Reset overrides all other inputs, including mid-operation; a partially computed result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a into sa, b into sb, borrow=0, count=0, busy=1, go RUN. start=0 -> stay.
- RUN: one bit per cycle.
  - d = sa[0] ^ sb[0] ^ borrow
  - borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)
  - The result register shifts right with d entering at the MSB; sa and sb shift right; count increments.
  - After the WIDTH-th bit (count == WIDTH-1), go DONE.
- Entering DONE: diff <= result register, borrow_out <= borrow_next, busy=0, done=1 for exactly one cycle.
- DONE: always returns to IDLE next cycle. If start=1 in DONE, it is accepted as in IDLE (back-to-back operation, go RUN directly).
- start while busy=1 (RUN) is ignored. It is not queued, and a/b changes have no effect.
- Latency: start accepted at edge N -> done=1 in the cycle after edge N+WIDTH, so done is visible WIDTH+1 cycles after start is sampled. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- diff and borrow_out hold their last values until the next DONE entry or reset. They do not change during RUN.
- Arithmetic: unsigned modulo 2^WIDTH. borrow_out equals the inverted carry of a + ~b + 1. Equal operands give diff=0, borrow_out=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit) = signed two's-complement overflow, (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Registered and updated together with diff on DONE entry.
  - Reset value 0; held like diff.
  - Operand sign bits are latched at start.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8, reset then start with a=10, b=3 -> busy=1 for 8 cycles; done=1 exactly 9 cycles after start sampled; diff=8'h07, borrow_out=0.
2. a=3, b=10 -> diff=8'hF9, borrow_out=1. a=8'hFF, b=8'hFF -> diff=0, borrow_out=0. a=0, b=1 -> diff=8'hFF, borrow_out=1.
3. Start a=20, b=5; pulse start with a=1, b=2 during RUN cycle 3 -> ignored; diff=8'h0F, borrow_out=0, single done pulse.
4. Back-to-back: hold start=1 through DONE with a=100, b=50 -> new RUN begins with no IDLE cycle; first done gives the prior result, second done gives diff=8'h32 after a further 9 cycles.
5. Reset mid-operation: rst_n=0 during RUN cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0. A subsequent start with a=7, b=7 completes with diff=0.
6. With SERIAL_SUB_OVF_EN defined:
   - a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1.
   - a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1.
   - a=8'h05, b=8'h03 -> ovf=0.
